// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read controller slice.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

    // Depth of the output skid buffer (words).
    localparam int BUF_DEPTH   = 2;
    // Width of the completed-frame counter.
    localparam int FRAME_CNT_W = 16;

    // Even parity (XOR reduction) of a word, zero-extended to 64 bits by the caller.
    function automatic logic calc_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the upstream FIFO, the read controller and the
// downstream consumer. out_parity exists only when FIFO_RD_PARITY_EN is defined.
interface fifo_rd_ctrl_if #(
    parameter int SIZE = 8
) ();
    import fifo_pkg::*;

    logic                   e_flag;
    logic [SIZE-1:0]        fifo_data;
    logic                   rd_req;
    logic                   flush;
    logic [SIZE-1:0]        out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef FIFO_RD_PARITY_EN
    logic                   out_parity;
`endif

    // Environment side: drives the FIFO status/data and the consumer ready.
    modport master (
        output e_flag, fifo_data, flush, out_ready,
`ifdef FIFO_RD_PARITY_EN
        input  out_parity,
`endif
        input  rd_req, out_data, out_valid, out_last, frame_cnt
    );

    // Controller side.
    modport slave (
        input  e_flag, fifo_data, flush, out_ready,
`ifdef FIFO_RD_PARITY_EN
        output out_parity,
`endif
        output rd_req, out_data, out_valid, out_last, frame_cnt
    );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO-ordered output buffer. Slot 0 is always the head word, so
// dout comes straight from a register.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [SIZE-1:0] din,
    output logic [SIZE-1:0] dout,
    output logic [1:0]      occ
);

    logic [SIZE-1:0] mem_r [BUF_DEPTH];
    logic [1:0]      occ_r;

    // Storage and occupancy update; a push while full with no pop is dropped.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            occ_r    <= 2'd0;
            mem_r[0] <= {SIZE{1'b0}};
            mem_r[1] <= {SIZE{1'b0}};
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        mem_r[0] <= din;
                        occ_r    <= 2'd1;
                    end else if (occ_r == 2'd1) begin
                        mem_r[1] <= din;
                        occ_r    <= 2'd2;
                    end else begin
                        occ_r    <= occ_r;
                    end
                end
                2'b01: begin
                    if (occ_r != 2'd0) begin
                        mem_r[0] <= mem_r[1];
                        occ_r    <= occ_r - 2'd1;
                    end else begin
                        occ_r    <= occ_r;
                    end
                end
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        mem_r[0] <= mem_r[1];
                        mem_r[1] <= din;
                    end else begin
                        mem_r[0] <= din;
                        occ_r    <= 2'd1;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign dout = mem_r[0];
    assign occ  = occ_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: issues pops to an upstream FIFO (1-cycle read latency),
// collects returned words in a 2-entry skid buffer and presents them as a
// framed valid/ready stream with a completed-frame counter.
// Optional feature: define FIFO_RD_PARITY_EN to add out_parity (XOR of out_data).
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_rd_ctrl_if.slave       bus
);

    localparam int              BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    rd_state_e              state_r;
    logic                   inflight_r;
    logic [BEAT_W-1:0]      beat_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;

    logic [1:0]             occ_s;
    logic [SIZE-1:0]        head_s;
    logic                   out_valid_s;
    logic                   out_last_s;
    logic                   pop_s;
    logic                   push_s;
    logic [2:0]             pending_s;
    logic                   rd_req_s;

    // Issue logic: keep buffered plus in-flight words (after this cycle's pop) below 2.
    always_comb begin
        out_valid_s = (occ_s != 2'd0);
        out_last_s  = out_valid_s && (beat_r == LAST_BEAT);
        pop_s       = out_valid_s && bus.out_ready;
        push_s      = inflight_r && !bus.flush;
        pending_s   = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        rd_req_s    = !rst && !bus.flush && (state_r != FLUSH) && !bus.e_flag
                      && (pending_s < 3'd2);
    end

    rd_skid_buf #(.SIZE(SIZE)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.flush),
        .push (push_s),
        .pop  (pop_s),
        .din  (bus.fifo_data),
        .dout (head_s),
        .occ  (occ_s)
    );

    // Control FSM with in-flight tracking, beat and frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            inflight_r  <= 1'b0;
            beat_r      <= {BEAT_W{1'b0}};
            frame_cnt_r <= {FRAME_CNT_W{1'b0}};
        end else if (bus.flush) begin
            state_r    <= FLUSH;
            inflight_r <= 1'b0;
            beat_r     <= {BEAT_W{1'b0}};
        end else begin
            inflight_r <= rd_req_s;
            if (pop_s) begin
                if (beat_r == LAST_BEAT) begin
                    beat_r      <= {BEAT_W{1'b0}};
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end else begin
                    beat_r      <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                beat_r <= beat_r;
            end
            case (state_r)
                IDLE: begin
                    if (rd_req_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // pending_s is next cycle's occupancy; rd_req_s is next inflight.
                    if ((pending_s == 3'd0) && !rd_req_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req    = rd_req_s;
    assign bus.out_data  = head_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_last  = out_last_s;
    assign bus.frame_cnt = frame_cnt_r;

`ifdef FIFO_RD_PARITY_EN
    assign bus.out_parity = calc_parity(64'(head_s));
`endif

endmodule
